// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART tx path: req_valid -> req_ack next cycle -> tx_start the cycle after.
// Producers hold req_valid until acked; one word in flight, paced by tx_done + GAP_CYCLES; define UART_TX_WDOG_EN for the tx_done watchdog.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int WORD_W      = 16,
    parameter int ID_W        = 2,
    parameter int GAP_CYCLES  = 16,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WORD_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ack,
    output logic [WORD_W-1:0]        tx_data,
    output logic                     tx_start,
    input  logic                     tx_done,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic                     wdog_err
);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, GAP} state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]     req_ack_q, req_ack_d;
    logic                tx_start_q, tx_start_d;
    logic [WORD_W-1:0]   tx_data_q, tx_data_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic                busy_q, busy_d;

    logic                pick_vld;
    logic [ID_W-1:0]     pick_id;
    int                  scan_idx;
    logic                wdog_hit;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        scan_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            if (!pick_vld && req_valid[ID_W'(scan_idx)]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(scan_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gap_cnt_q  <= '0;
            rr_ptr_q   <= '0;
            req_ack_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            req_ack_q  <= req_ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    // tx_done matters only in WAIT; a watchdog timeout ends WAIT the same way.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: if (pick_vld) state_d = LOAD;
            LOAD: state_d = SEND;
            SEND: state_d = WAIT;
            WAIT: begin
                if (tx_done || wdog_hit) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else                 gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one appears in the cycle its state is occupied.
    always_comb begin
        req_ack_d  = '0;
        tx_start_d = (state_d == SEND);
        busy_d     = (state_d != IDLE);
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        if (state_q == IDLE && pick_vld) begin
            req_ack_d[pick_id] = 1'b1;
            tx_data_d          = req_data[pick_id*WORD_W +: WORD_W];
            grant_id_d         = pick_id;
            rr_ptr_d           = (pick_id == ID_W'(NREQ - 1)) ? '0 : pick_id + 1'b1;
        end
    end

`ifdef UART_TX_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;

    assign wdog_hit = (state_q == WAIT) && !tx_done && (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

    always_comb begin
        wdog_cnt_d = (state_q == WAIT) ? wdog_cnt_q + 1'b1 : '0;
        wdog_err_d = wdog_err_q | wdog_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES > 0);
    assign wdog_hit    = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    assign req_ack  = req_ack_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a negedge monitor models the UART and the requesters and
// scores every tx_start against a queue of expected (grant, word) pairs filled by the stimulus.
module tb_uart_tx_arbiter;

    localparam int NREQ        = 4;
    localparam int WORD_W      = 16;
    localparam int ID_W        = 2;
    localparam int GAP_CYCLES  = 16;
    localparam int WDOG_CYCLES = 100;
    localparam int UART_DLY    = 10;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [WORD_W-1:0] dat;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*WORD_W-1:0] req_data = '0;
    logic [NREQ-1:0]        req_ack;
    logic [WORD_W-1:0]      tx_data;
    logic                   tx_start;
    logic                   tx_done;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;
    logic                   wdog_err;

    logic auto_done = 1'b0;
    logic stray_done = 1'b0;
    logic uart_auto = 1'b0;
    logic chk_gap = 1'b0;
    assign tx_done = auto_done | stray_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_start = 0;
    int ucnt = 0;
    int done_cyc = 0;
    int s0 = 0;
    int d0 = 0;
    bit arm_fall = 1'b0;
    bit arm_ack = 1'b0;
    logic [NREQ-1:0]   ack_prev = '0;
    logic [NREQ-1:0]   onehot;
    exp_t              e;
    int                issued[NREQ];
    int                sent[NREQ];
    logic [WORD_W-1:0] wdat[NREQ][3];
    exp_t              exp_q[$];

    uart_tx_arbiter #(
        .NREQ(NREQ), .WORD_W(WORD_W), .ID_W(ID_W),
        .GAP_CYCLES(GAP_CYCLES), .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ack(req_ack),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_word(input int id, input int k);
        exp_q.push_back(exp_t'({ID_W'(id), wdat[id][k]}));
    endtask

    task automatic wait_start(input int max);
        for (int k = 0; k < max; k++) begin
            @(negedge clk); #1;
            if (tx_start) break;
        end
        check("start_seen", tx_start, 1);
    endtask

    task automatic wait_idle(input int max);
        for (int k = 0; k < max; k++) begin
            @(negedge clk); #1;
            if (!busy && req_valid == '0 && ucnt == 0 && exp_q.size() == 0) break;
        end
        check("idle_reached", {busy, req_valid}, 0);
    endtask

    task automatic stray_pulse();
        stray_done = 1'b1;
        @(negedge clk); #1;
        stray_done = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack"}, req_ack, 0);
        check({tag, "_start"}, tx_start, 0);
        check({tag, "_data"}, tx_data, 0);
        check({tag, "_gid"}, grant_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wdog"}, wdog_err, 0);
    endtask

    // Monitor: scoreboard, gap timing, UART model and requester model.
    always @(negedge clk) begin
        auto_done = 1'b0;
        if (!rst) begin
            ucnt     = 0;
            ack_prev = '0;
        end else begin
            if (tx_start) begin
                n_start++;
                check("start_vs_ack", req_ack, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_start", tx_start, 0);
                end else begin
                    e = exp_q.pop_front();
                    onehot = '0;
                    onehot[e.id] = 1'b1;
                    check("tx_data", tx_data, e.dat);
                    check("grant_id", grant_id, e.id);
                    check("ack_before_start", ack_prev, onehot);
                end
            end
            if (chk_gap) begin
                if (arm_fall && !busy) begin
                    check("gap_busy_fall", cyc - done_cyc, GAP_CYCLES + 1);
                    arm_fall = 1'b0;
                end
                if (arm_ack && req_ack != '0) begin
                    check("gap_next_ack", cyc - done_cyc, GAP_CYCLES + 2);
                    arm_ack = 1'b0;
                end
            end
            if (tx_start && uart_auto) begin
                ucnt = UART_DLY;
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) begin
                    auto_done = 1'b1;
                    done_cyc  = cyc;
                    arm_fall  = chk_gap;
                    arm_ack   = chk_gap;
                end
            end
            ack_prev = req_ack;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_ack[i]) begin
                sent[i]++;
                req_valid[i] = 1'b0;
            end
            if (!req_valid[i] && sent[i] < issued[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*WORD_W +: WORD_W] = wdat[i][sent[i]];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wdat[0][0] = 16'h1111; wdat[0][1] = 16'h2222; wdat[0][2] = 16'h0F0F;
        wdat[1][0] = 16'h0A3C; wdat[1][1] = 16'h3333; wdat[1][2] = 16'h0000;
        wdat[2][0] = 16'h4444; wdat[2][1] = 16'h5A5A; wdat[2][2] = 16'h0000;
        wdat[3][0] = 16'hBEEF; wdat[3][1] = 16'h6666; wdat[3][2] = 16'hC3C3;
        for (int i = 0; i < NREQ; i++) begin
            issued[i] = 0;
            sent[i]   = 0;
        end

        // Reset values
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single word from requester 1: ack one cycle after request, start the next
        uart_auto = 1'b1;
        expect_word(1, 0);
        @(posedge clk); #1 issued[1] = 1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("lat_ack", req_ack, 4'b0010);
        check("lat_busy", busy, 1);
        @(negedge clk); #1;
        check("lat_start", tx_start, 1);
        wait_idle(100);

        // Asynchronous reset in the middle of WAIT
        uart_auto = 1'b0;
        expect_word(3, 0);
        @(posedge clk); #1 issued[3] = 1;
        wait_start(20);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_outputs_zero("midwait_rst");
        s0 = n_start;
        @(negedge clk); #1 rst = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("rst_no_start", n_start - s0, 0);
        check("rst_idle_busy", busy, 0);

        // Round robin with all four requesters, requester 0 re-asserting; gap timing checked
        uart_auto = 1'b1;
        chk_gap   = 1'b1;
        expect_word(0, 0);
        expect_word(1, 1);
        expect_word(2, 0);
        expect_word(3, 1);
        expect_word(0, 1);
        @(posedge clk); #1;
        issued[0] = 2; issued[1] = 2; issued[2] = 1; issued[3] = 2;
        wait_idle(600);
        chk_gap = 1'b0;

        // Stray tx_done in IDLE, at SEND and in GAP
        uart_auto = 1'b0;
        s0 = n_start;
        stray_pulse();
        repeat (3) @(negedge clk);
        #1;
        check("stray_idle_busy", busy, 0);
        check("stray_idle_start", n_start - s0, 0);
        expect_word(2, 1);
        @(posedge clk); #1 issued[2] = 2;
        wait_start(20);
        stray_pulse();
        repeat (30) @(negedge clk);
        #1 check("wait_holds", busy, 1);
        d0 = cyc;
        stray_pulse();
        repeat (4) @(negedge clk);
        #1 stray_pulse();
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            @(negedge clk); #1;
        end
        check("gap_after_stray", cyc - d0, GAP_CYCLES + 1);

        // No tx_done at all: watchdog (when built in) or indefinite WAIT
        expect_word(3, 2);
        @(posedge clk); #1 issued[3] = 3;
        wait_start(20);
`ifdef UART_TX_WDOG_EN
        repeat (WDOG_CYCLES) @(negedge clk);
        #1 check("wdog_before", wdog_err, 0);
        @(negedge clk); #1 check("wdog_set", wdog_err, 1);
`else
        repeat (150) @(negedge clk);
        #1;
        check("nowdog_busy", busy, 1);
        check("nowdog_err", wdog_err, 0);
        stray_pulse();
`endif
        uart_auto = 1'b1;
        expect_word(0, 2);
        @(posedge clk); #1 issued[0] = 3;
        wait_idle(200);
`ifdef UART_TX_WDOG_EN
        check("wdog_sticky", wdog_err, 1);
`else
        check("wdog_tied", wdog_err, 0);
`endif
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
